mem_port_arbiter: RTL

//  Shares one unified memory bus between the fetch stage (PCF -> InstrF) and the memory

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter_bus_wait_timer.sv | 29 ++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    // Bus ownership: idle, instruction fetch in flight, or data access in flight.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    // Fetches and loads always read the whole word.
    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side (fetch / memory stage) and bus-side signals of the memory port arbiter.
interface mem_port_arbiter_if;
    // fetch stage
    logic        IReqF;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        IReadyF;
    logic        MemStallF;
    // memory stage
    logic        MemReqM;
    logic        MemWriteM;
    logic [3:0]  ByteEnM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic        MemAdvM;
    logic [31:0] ReadDataM;
    logic        MemStallM;
    // unified memory bus
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [31:0] BusWData;
    logic [3:0]  BusBe;
    logic        BusAck;
    logic [31:0] BusRData;
    logic        BusTimeout;

    // The arbiter itself.
    modport master (
        input  IReqF, PCF, MemReqM, MemWriteM, ByteEnM, ALUOutM, WriteDataM, MemAdvM,
        input  BusAck, BusRData,
        output InstrF, IReadyF, MemStallF, ReadDataM, MemStallM,
        output BusReq, BusWe, BusAddr, BusWData, BusBe, BusTimeout
    );

    // The pipeline plus the memory slave surrounding the arbiter.
    modport slave (
        output IReqF, PCF, MemReqM, MemWriteM, ByteEnM, ALUOutM, WriteDataM, MemAdvM,
        output BusAck, BusRData,
        input  InstrF, IReadyF, MemStallF, ReadDataM, MemStallM,
        input  BusReq, BusWe, BusAddr, BusWData, BusBe, BusTimeout
    );
endinterface

// File: rtl/mem_port_arbiter_bus_wait_timer.sv
// Counts cycles a bus request waits for its acknowledge and flags expiry.
module bus_wait_timer #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    // The last waiting cycle before abort; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Clear on every new grant, count cycles spent waiting for acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expire = (TIMEOUT != 0) && i_enable && (r_count == LAST_CNT);
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory bus between instruction fetch and data access,
// buffers the last fetched word and last loaded word, and aborts stuck requests.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.master bus
);
    arb_state_t  r_state;
    arb_state_t  w_state_next;

    logic        r_bus_req, r_bus_we;
    logic [31:0] r_bus_addr, r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic        r_bus_timeout;

    logic        w_bus_req_next, w_bus_we_next;
    logic [31:0] w_bus_addr_next, w_bus_wdata_next;
    logic [3:0]  w_bus_be_next;

    logic [31:0] r_ibuf, r_itag, r_dbuf;
    logic        r_ibuf_valid;
    logic        r_done_m;

    logic        w_expire;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_fetch_ack, w_data_ack;
    logic        w_i_ready;
    logic        w_data_pend, w_fetch_pend;
    logic        w_can_grant, w_grant;

    // An abort is handled exactly like an acknowledge that returned zero.
    assign w_ack       = r_bus_req & (bus.BusAck | w_expire);
    assign w_rdata     = bus.BusAck ? bus.BusRData : '0;
    assign w_fetch_ack = (r_state == FETCH) & w_ack;
    assign w_data_ack  = (r_state == DATA) & w_ack;

    assign w_i_ready = (w_fetch_ack & (r_bus_addr == bus.PCF)) |
                       (r_ibuf_valid & (r_itag == bus.PCF));

    // The data access completing this cycle is no longer pending, so it is not re-issued.
    assign w_data_pend  = bus.MemReqM & ~r_done_m & ~w_data_ack;
    assign w_fetch_pend = bus.IReqF & ~w_i_ready;
    assign w_can_grant  = (r_state == IDLE) | w_ack;
    assign w_grant      = w_can_grant & (w_data_pend | w_fetch_pend);

    bus_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_grant),
        .i_enable (r_bus_req & ~bus.BusAck),
        .o_expire (w_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next grant: data beats fetch, nothing preempts an in-flight transaction.
    always_comb begin
        w_state_next = r_state;
        if (w_can_grant) begin
            if (w_data_pend) begin
                w_state_next = DATA;
            end else if (w_fetch_pend) begin
                w_state_next = FETCH;
            end else begin
                w_state_next = IDLE;
            end
        end
    end

    // Next bus command and the combinational core-side outputs.
    always_comb begin
        w_bus_req_next   = 1'b0;
        w_bus_we_next    = 1'b0;
        w_bus_addr_next  = '0;
        w_bus_wdata_next = '0;
        w_bus_be_next    = '0;
        if (!w_can_grant) begin
            w_bus_req_next   = r_bus_req;
            w_bus_we_next    = r_bus_we;
            w_bus_addr_next  = r_bus_addr;
            w_bus_wdata_next = r_bus_wdata;
            w_bus_be_next    = r_bus_be;
        end else if (w_data_pend) begin
            w_bus_req_next   = 1'b1;
            w_bus_we_next    = bus.MemWriteM;
            w_bus_addr_next  = bus.ALUOutM;
            w_bus_wdata_next = bus.WriteDataM;
            w_bus_be_next    = bus.MemWriteM ? bus.ByteEnM : BE_WORD;
        end else if (w_fetch_pend) begin
            w_bus_req_next   = 1'b1;
            w_bus_addr_next  = bus.PCF;
            w_bus_be_next    = BE_WORD;
        end

        bus.IReadyF   = w_i_ready;
        bus.InstrF    = w_fetch_ack ? w_rdata : r_ibuf;
        bus.MemStallF = bus.IReqF & ~w_i_ready;
        bus.ReadDataM = (w_data_ack & ~r_bus_we) ? w_rdata : r_dbuf;
        bus.MemStallM = bus.MemReqM & ~r_done_m & ~w_data_ack;
    end

    // Registered bus command; stays frozen while a request waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
        end else begin
            r_bus_req   <= w_bus_req_next;
            r_bus_we    <= w_bus_we_next;
            r_bus_addr  <= w_bus_addr_next;
            r_bus_wdata <= w_bus_wdata_next;
            r_bus_be    <= w_bus_be_next;
        end
    end

    // Fetch/load buffers, data-done flag and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ibuf        <= '0;
            r_itag        <= '0;
            r_ibuf_valid  <= 1'b0;
            r_dbuf        <= '0;
            r_done_m      <= 1'b0;
            r_bus_timeout <= 1'b0;
        end else begin
            if (w_fetch_ack) begin
                r_ibuf       <= w_rdata;
                r_itag       <= r_bus_addr;
                r_ibuf_valid <= 1'b1;
            end
            if (w_data_ack && !r_bus_we) begin
                r_dbuf <= w_rdata;
            end
            // Advancing retires the access, even one acknowledged in the same cycle.
            if (bus.MemAdvM) begin
                r_done_m <= 1'b0;
            end else if (w_data_ack) begin
                r_done_m <= 1'b1;
            end
            if (w_expire) begin
                r_bus_timeout <= 1'b1;
            end
        end
    end

    assign bus.BusReq     = r_bus_req;
    assign bus.BusWe      = r_bus_we;
    assign bus.BusAddr    = r_bus_addr;
    assign bus.BusWData   = r_bus_wdata;
    assign bus.BusBe      = r_bus_be;
    assign bus.BusTimeout = r_bus_timeout;
endmodule
